// File: rtl/cpu6_sim_checker_pkg.sv
// cpu6_sim_checker_pkg: shared checker constants, result codes and FSM state encodings
//   CPU6_XLEN          default datapath width
//   CPU6_CHK_FC_*      fail_code values
//   cpu6_chk_st_e      checker FSM states
//   sel_w()            probe-select width, never below one bit
package cpu6_sim_checker_pkg;
   localparam int CPU6_XLEN = 32;
   localparam logic [1:0] CPU6_CHK_FC_NONE     = 2'd0;
   localparam logic [1:0] CPU6_CHK_FC_MISMATCH = 2'd1;
   localparam logic [1:0] CPU6_CHK_FC_ORDER    = 2'd2;
   localparam logic [1:0] CPU6_CHK_FC_TIMEOUT  = 2'd3;
   typedef enum logic [1:0] {
      CPU6_CHK_ST_RUN  = 2'd0,
      CPU6_CHK_ST_PASS = 2'd1,
      CPU6_CHK_ST_FAIL = 2'd2,
      CPU6_CHK_ST_TOUT = 2'd3
   } cpu6_chk_st_e;
   function automatic int sel_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cpu6_chk_probe_mux.sv
// cpu6_chk_probe_mux: combinational NPROBE:1 selector of XLEN-bit probe words
//   probe  flattened probe words, word k at [k*XLEN +: XLEN]
//   sel    index of the word to forward
//   val    selected word
module cpu6_chk_probe_mux #(
   parameter int XLEN   = 32,
   parameter int NPROBE = 8,
   parameter int SELW   = 3
) (
   input  logic [NPROBE*XLEN-1:0] probe,
   input  logic [SELW-1:0]        sel,
   output logic [XLEN-1:0]        val
);
   assign val = probe[sel*XLEN +: XLEN];
endmodule

// File: rtl/cpu6_sim_checker.sv
// cpu6_sim_checker: walks an ordered checkpoint list against PC/probe values, reporting sticky pass/fail/timeout
//   clk, reset (async active-low), sample_en qualifies a sample
//   pc, probe                    observed core state
//   chk_pc, chk_sel, chk_exp     checkpoint table, num_chk active entries
//   busy, done, pass, fail       result flags
//   fail_code, fail_idx          failure reason and checkpoint index
//   chk_idx, sample_cnt          progress and qualified-sample count
module cpu6_sim_checker
   import cpu6_sim_checker_pkg::*;
#(
   parameter int XLEN        = CPU6_XLEN,
   parameter int NPROBE      = 8,
   parameter int NCHK        = 4,
   parameter int TIMEOUT_CYC = 4096,
   parameter bit ORDERED     = 1'b1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sample_en,
   input  logic [XLEN-1:0]                 pc,
   input  logic [NPROBE*XLEN-1:0]          probe,
   input  logic [NCHK*XLEN-1:0]            chk_pc,
   input  logic [NCHK*sel_w(NPROBE)-1:0]   chk_sel,
   input  logic [NCHK*XLEN-1:0]            chk_exp,
   input  logic [$clog2(NCHK+1)-1:0]       num_chk,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic                            fail,
   output logic [1:0]                      fail_code,
   output logic [$clog2(NCHK):0]           fail_idx,
   output logic [$clog2(NCHK):0]           chk_idx,
   output logic [$clog2(TIMEOUT_CYC):0]    sample_cnt
);
   localparam int SELW = sel_w(NPROBE);
   localparam int IW   = $clog2(NCHK) + 1;
   localparam int CW   = $clog2(TIMEOUT_CYC) + 1;

   cpu6_chk_st_e    st, st_nx;
   logic [XLEN-1:0] prev_pc, cur_pc, cur_exp, cur_val;
   logic [SELW-1:0] cur_sel;
   logic [NCHK-1:0] later;
   logic [IW-1:0]   idx_nx, active;
   logic [CW-1:0]   cnt_nx;
   logic [1:0]      code_nx;
   logic            first, new_pc, hit, ok, last, ooo, tout;

   // chk_idx only reaches NCHK once the run has passed, so the table reads are always in range while RUN
   assign cur_pc  = chk_pc[chk_idx*XLEN +: XLEN];
   assign cur_exp = chk_exp[chk_idx*XLEN +: XLEN];
   assign cur_sel = chk_sel[chk_idx*SELW +: SELW];

   cpu6_chk_probe_mux #(.XLEN(XLEN), .NPROBE(NPROBE), .SELW(SELW)) u_mux (
      .probe (probe),
      .sel   (cur_sel),
      .val   (cur_val)
   );

   assign active = IW'(num_chk);
   assign new_pc = first | (pc != prev_pc);
   assign hit    = new_pc & (chk_idx < active) & (pc == cur_pc);
   assign ok     = hit & (cur_val == cur_exp);
   assign idx_nx = chk_idx + 1'b1;
   assign last   = idx_nx == active;
   assign cnt_nx = sample_cnt + CW'(sample_cnt != CW'(TIMEOUT_CYC));
   assign tout   = cnt_nx == CW'(TIMEOUT_CYC);
   // a current-checkpoint hit outranks a later-checkpoint alias at the same PC
   assign ooo    = ORDERED & new_pc & (pc != cur_pc) & (|later);

   for (genvar j = 0; j < NCHK; j++) begin : g_later
      assign later[j] = (IW'(j) > chk_idx) & (IW'(j) < active) & (pc == chk_pc[j*XLEN +: XLEN]);
   end

   always_comb begin
      st_nx   = CPU6_CHK_ST_RUN;
      code_nx = CPU6_CHK_FC_TIMEOUT;
      if (num_chk == '0 || (ok && last)) st_nx = CPU6_CHK_ST_PASS;
      else if (hit && !ok) begin
         st_nx   = CPU6_CHK_ST_FAIL;
         code_nx = CPU6_CHK_FC_MISMATCH;
      end else if (ooo) begin
         st_nx   = CPU6_CHK_ST_FAIL;
         code_nx = CPU6_CHK_FC_ORDER;
      end else if (tout) st_nx = CPU6_CHK_ST_TOUT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= CPU6_CHK_ST_RUN;
         busy       <= 1'b1;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         fail_code  <= CPU6_CHK_FC_NONE;
         fail_idx   <= '0;
         chk_idx    <= '0;
         sample_cnt <= '0;
         prev_pc    <= '0;
         first      <= 1'b1;
      end else if (sample_en && st == CPU6_CHK_ST_RUN) begin
         st         <= st_nx;
         busy       <= st_nx == CPU6_CHK_ST_RUN;
         done       <= st_nx != CPU6_CHK_ST_RUN;
         pass       <= st_nx == CPU6_CHK_ST_PASS;
         fail       <= st_nx == CPU6_CHK_ST_FAIL || st_nx == CPU6_CHK_ST_TOUT;
         sample_cnt <= cnt_nx;
         prev_pc    <= pc;
         first      <= 1'b0;
         if (ok) chk_idx <= idx_nx;
         if (st_nx == CPU6_CHK_ST_FAIL || st_nx == CPU6_CHK_ST_TOUT) begin
            fail_code <= code_nx;
            fail_idx  <= ok ? idx_nx : chk_idx;
         end
      end
   end
endmodule

// File: tb/tb_cpu6_sim_checker.sv
// tb_cpu6_sim_checker: scoreboard bench for cpu6_sim_checker (ordered and unordered instances side by side)
module tb_cpu6_sim_checker;
   localparam logic [31:0] G   = 32'hffffffee;
   localparam logic [31:0] BAD = 32'hffffffef;

   logic clk = 1'b0, reset = 1'b0, sample_en = 1'b0;
   logic [31:0]  pc = '0;
   logic [255:0] probe = '0;
   logic [63:0]  chk_pc  = {32'h30, 32'h1c};
   logic [5:0]   chk_sel = {3'd3, 3'd7};
   logic [63:0]  chk_exp = {G, G};
   logic [1:0]   num_chk = 2'd2;

   logic a_busy, a_done, a_pass, a_fail, b_busy, b_done, b_pass, b_fail;
   logic [1:0] a_code, a_fidx, a_idx, b_code, b_fidx, b_idx;
   logic [4:0] a_cnt, b_cnt;

   always #5 clk = ~clk;

   cpu6_sim_checker #(.XLEN(32), .NPROBE(8), .NCHK(2), .TIMEOUT_CYC(16), .ORDERED(1'b1)) dut_a (
      .clk(clk), .reset(reset), .sample_en(sample_en), .pc(pc), .probe(probe),
      .chk_pc(chk_pc), .chk_sel(chk_sel), .chk_exp(chk_exp), .num_chk(num_chk),
      .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
      .fail_idx(a_fidx), .chk_idx(a_idx), .sample_cnt(a_cnt)
   );

   cpu6_sim_checker #(.XLEN(32), .NPROBE(8), .NCHK(2), .TIMEOUT_CYC(16), .ORDERED(1'b0)) dut_b (
      .clk(clk), .reset(reset), .sample_en(sample_en), .pc(pc), .probe(probe),
      .chk_pc(chk_pc), .chk_sel(chk_sel), .chk_exp(chk_exp), .num_chk(num_chk),
      .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
      .fail_idx(b_fidx), .chk_idx(b_idx), .sample_cnt(b_cnt)
   );

   typedef struct {
      logic       done, pass, fail;
      logic [1:0] code, fidx, idx;
      logic [4:0] cnt;
      logic       b_done, b_pass;
   } exp_t;

   exp_t q[$];
   int   checks = 0, passed = 0;
   logic sampled = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   always @(posedge clk) sampled <= sample_en & reset;

   always @(negedge clk) begin
      exp_t e;
      if (sampled) begin
         if (q.size() == 0) chk("scoreboard_pop", q.size(), 1);
         else begin
            e = q.pop_front();
            chk("busy", a_busy, !e.done);
            chk("done", a_done, e.done);
            chk("pass", a_pass, e.pass);
            chk("fail", a_fail, e.fail);
            chk("fail_code", a_code, e.code);
            chk("fail_idx", a_fidx, e.fidx);
            chk("chk_idx", a_idx, e.idx);
            chk("sample_cnt", a_cnt, e.cnt);
            chk("unord_done", b_done, e.b_done);
            chk("unord_pass", b_pass, e.b_pass);
         end
      end
   end

   task automatic step(input logic [31:0] p, x3, mepc, input logic d, ps, f,
                       input logic [1:0] code, fidx, idx, input logic [4:0] cnt, input logic bd, bp);
      pc = p;
      probe[3*32 +: 32] = x3;
      probe[7*32 +: 32] = mepc;
      sample_en = 1'b1;
      q.push_back('{d, ps, f, code, fidx, idx, cnt, bd, bp});
      @(posedge clk);
      #1 sample_en = 1'b0;
   endtask

   task automatic run(input logic [31:0] p, x3, mepc, input logic [1:0] idx, input logic [4:0] cnt);
      step(p, x3, mepc, 0, 0, 0, 2'd0, 2'd0, idx, cnt, 0, 0);
   endtask

   task automatic do_reset();
      sample_en = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", a_busy, 1);
      chk("rst_done", a_done, 0);
      chk("rst_pass", a_pass, 0);
      chk("rst_fail", a_fail, 0);
      chk("rst_code", a_code, 0);
      chk("rst_fidx", a_fidx, 0);
      chk("rst_idx", a_idx, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_unord_idx", b_idx, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // csrrc-style pass, later PCs ignored
      do_reset();
      run(32'h00, 0, 0, 2'd0, 5'd1);
      run(32'h1c, 0, G, 2'd1, 5'd2);
      run(32'h20, 0, G, 2'd1, 5'd3);
      step(32'h30, G, G, 1, 1, 0, 2'd0, 2'd0, 2'd2, 5'd4, 1, 1);
      step(32'h34, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd2, 5'd4, 1, 1);
      // value mismatch at chk1 is sticky
      do_reset();
      run(32'h1c, 0, G, 2'd1, 5'd1);
      step(32'h30, BAD, G, 1, 0, 1, 2'd1, 2'd1, 2'd1, 5'd2, 1, 0);
      step(32'h1c, G, G, 1, 0, 1, 2'd1, 2'd1, 2'd1, 5'd2, 1, 0);
      step(32'h30, G, G, 1, 0, 1, 2'd1, 2'd1, 2'd1, 5'd2, 1, 0);
      // stall at 0x1c with the probe then wrong: a re-evaluation would fail
      do_reset();
      run(32'h00, 0, 0, 2'd0, 5'd1);
      run(32'h1c, 0, G, 2'd1, 5'd2);
      for (int i = 3; i <= 6; i++) run(32'h1c, 0, 0, 2'd1, 5'(i));
      run(32'h20, 0, 0, 2'd1, 5'd7);
      // out of order: ordered instance fails, unordered keeps running then passes
      do_reset();
      run(32'h00, 0, 0, 2'd0, 5'd1);
      step(32'h30, G, G, 1, 0, 1, 2'd2, 2'd0, 2'd0, 5'd2, 0, 0);
      step(32'h1c, G, G, 1, 0, 1, 2'd2, 2'd0, 2'd0, 5'd2, 0, 0);
      step(32'h30, G, G, 1, 0, 1, 2'd2, 2'd0, 2'd0, 5'd2, 1, 1);
      // timeout on the 16th sample
      do_reset();
      for (int i = 1; i <= 15; i++) run(32'h100 + 32'(4*i), 0, 0, 2'd0, 5'(i));
      step(32'h200, 0, 0, 1, 0, 1, 2'd3, 2'd0, 2'd0, 5'd16, 1, 0);
      step(32'h204, 0, 0, 1, 0, 1, 2'd3, 2'd0, 2'd0, 5'd16, 1, 0);
      // final match on the timeout sample wins
      do_reset();
      run(32'h1c, 0, G, 2'd1, 5'd1);
      for (int i = 2; i <= 15; i++) run(32'h100 + 32'(4*i), 0, 0, 2'd1, 5'(i));
      step(32'h30, G, 0, 1, 1, 0, 2'd0, 2'd0, 2'd2, 5'd16, 1, 1);
      // asynchronous reset mid-run, then a clean restart from chk0
      do_reset();
      run(32'h1c, 0, G, 2'd1, 5'd1);
      do_reset();
      run(32'h1c, 0, G, 2'd1, 5'd1);
      step(32'h30, G, G, 1, 1, 0, 2'd0, 2'd0, 2'd2, 5'd2, 1, 1);
      @(negedge clk);
      #2 chk("scoreboard_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
